// File: rtl/uart_rx_deserializer.sv
// ----------------------------------------------------------------------------
// uart_rx_deserializer
//
// Serial front end of the UART receive path. The raw line is brought into the
// clock domain through a two-flop synchronizer. Every character is then
// sampled at the middle of each bit: start, 8 data bits (LSB first), parity
// and stop. The result is packed into the 11-bit frame word used by the
// downstream Receiver stage.
//
// Parameters:
//   CLKS_PER_BIT  system clocks per serial bit (must be >= 4)
//   PARITY_ODD    0 = even parity expected, 1 = odd parity expected
//
// Ports:
//   clk             system clock, rising edge
//   reset           asynchronous, active-low; clears all state while low
//   rxSerial        raw serial line, idle high, LSB-first data
//   informationBus  last frame {start, data[7:0], parity, stop};
//                   11'h7FF after reset (no frame received yet)
//   frameValid      one-cycle pulse in the cycle informationBus updates
//   parityError     parity mismatch on the last frame, held until next frame
//   framingError    stop sample was 0 on the last frame, held until next frame
//   busy            high from start detection until the return to IDLE
// ----------------------------------------------------------------------------
module uart_rx_deserializer #(
    parameter int CLKS_PER_BIT = 9600,
    parameter int PARITY_ODD   = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rxSerial,
    output logic [10:0] informationBus,
    output logic        frameValid,
    output logic        parityError,
    output logic        framingError,
    output logic        busy
);

    localparam int CW = $clog2(CLKS_PER_BIT) + 1;

    // Terminal counts. The START state only waits half a bit so that every
    // later sample lands in the middle of its bit.
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    localparam logic PARITY_SENSE = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rxState_t;

    rxState_t        state;
    rxState_t        stateNext;

    logic            syncMeta;
    logic            rxs;

    logic [CW-1:0]   counter;
    logic [CW-1:0]   counterNext;
    logic [2:0]      bitIdx;
    logic [2:0]      bitIdxNext;
    logic [7:0]      data;
    logic [7:0]      dataNext;
    logic            parityBit;
    logic            parityBitNext;
    logic            armed;
    logic            armedNext;

    logic [10:0]     busNext;
    logic            frameValidNext;
    logic            parityErrorNext;
    logic            framingErrorNext;
    logic            busyNext;

    logic            parityMismatch;

    // Two-flop synchronizer. Both stages reset high so that leaving reset
    // looks like an idle line rather than a start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            syncMeta <= 1'b1;
            rxs      <= 1'b1;
        end else begin
            syncMeta <= rxSerial;
            rxs      <= syncMeta;
        end
    end

    // Combined parity of the assembled character and the received parity bit.
    // With even parity the total must be 0, with odd parity it must be 1, so
    // folding PARITY_SENSE in makes any nonzero result an error.
    always_comb begin
        parityMismatch = (^data) ^ parityBit ^ PARITY_SENSE;
    end

    // State and datapath registers. Everything here, including the output
    // frame word, returns to its idle value the moment reset goes low, which
    // also throws away any partially received character.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            counter        <= '0;
            bitIdx         <= '0;
            data           <= '0;
            parityBit      <= 1'b0;
            armed          <= 1'b0;
            informationBus <= 11'h7FF;
            frameValid     <= 1'b0;
            parityError    <= 1'b0;
            framingError   <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state          <= stateNext;
            counter        <= counterNext;
            bitIdx         <= bitIdxNext;
            data           <= dataNext;
            parityBit      <= parityBitNext;
            armed          <= armedNext;
            informationBus <= busNext;
            frameValid     <= frameValidNext;
            parityError    <= parityErrorNext;
            framingError   <= framingErrorNext;
            busy           <= busyNext;
        end
    end

    // Next-state and output logic.
    //
    // The armed flag is what keeps a held-low line (a break, or the tail of a
    // frame whose stop sample was 0) from being taken as a fresh start bit:
    // a start is only accepted after IDLE has seen the line high at least once.
    // Because the stop sample of a good frame is high, the first IDLE cycle
    // after it re-arms, so a start bit that follows immediately is accepted.
    always_comb begin
        stateNext        = state;
        counterNext      = counter;
        bitIdxNext       = bitIdx;
        dataNext         = data;
        parityBitNext    = parityBit;
        armedNext        = armed;
        busNext          = informationBus;
        frameValidNext   = 1'b0;
        parityErrorNext  = parityError;
        framingErrorNext = framingError;
        busyNext         = busy;

        case (state)
            IDLE: begin
                busyNext = 1'b0;
                if (rxs) begin
                    armedNext = 1'b1;
                end else if (armed) begin
                    stateNext   = START;
                    counterNext = '0;
                    armedNext   = 1'b0;
                    busyNext    = 1'b1;
                end
            end

            START: begin
                // A line that is high again at mid-start-bit was a glitch.
                if (counter == HALF_LAST) begin
                    counterNext = '0;
                    if (!rxs) begin
                        stateNext  = DATA;
                        bitIdxNext = '0;
                    end else begin
                        stateNext = IDLE;
                        busyNext  = 1'b0;
                    end
                end else begin
                    counterNext = counter + 1'b1;
                end
            end

            DATA: begin
                if (counter == BIT_LAST) begin
                    counterNext      = '0;
                    dataNext[bitIdx] = rxs;
                    bitIdxNext       = bitIdx + 1'b1;
                    if (bitIdx == 3'd7) begin
                        stateNext = PARITY;
                    end
                end else begin
                    counterNext = counter + 1'b1;
                end
            end

            PARITY: begin
                if (counter == BIT_LAST) begin
                    counterNext   = '0;
                    parityBitNext = rxs;
                    stateNext     = STOP;
                end else begin
                    counterNext = counter + 1'b1;
                end
            end

            STOP: begin
                // Frames with errors are still delivered; only the flags
                // tell the downstream stage something went wrong.
                if (counter == BIT_LAST) begin
                    counterNext      = '0;
                    busNext          = {1'b0, data, parityBit, rxs};
                    parityErrorNext  = parityMismatch;
                    framingErrorNext = ~rxs;
                    frameValidNext   = 1'b1;
                    stateNext        = IDLE;
                    busyNext         = 1'b0;
                end else begin
                    counterNext = counter + 1'b1;
                end
            end

            default: begin
                stateNext   = IDLE;
                counterNext = '0;
                busyNext    = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_deserializer
//
// Directed bench for uart_rx_deserializer with CLKS_PER_BIT=16, even parity.
// Each transmitted character pushes its expected frame word and error flags
// onto a queue; a monitor pops and compares on every frameValid pulse.
// ----------------------------------------------------------------------------
module tb_uart_rx_deserializer;

    localparam int CPB = 16;

    typedef struct {
        logic [10:0] bus;
        logic        parErr;
        logic        frmErr;
    } expFrame_t;

    logic        clk;
    logic        reset;
    logic        rxSerial;
    logic [10:0] informationBus;
    logic        frameValid;
    logic        parityError;
    logic        framingError;
    logic        busy;

    expFrame_t   sbQ[$];
    int          checks;
    int          errors;
    int          validCount;
    int          busyCount;

    uart_rx_deserializer #(
        .CLKS_PER_BIT(CPB),
        .PARITY_ODD  (0)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rxSerial      (rxSerial),
        .informationBus(informationBus),
        .frameValid    (frameValid),
        .parityError   (parityError),
        .framingError  (framingError),
        .busy          (busy)
    );

    // 10 ns system clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: counts it and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Hold the line at one level for a full bit time; changes on falling edges.
    task automatic driveBit(input logic value);
        rxSerial = value;
        repeat (CPB) @(negedge clk);
    endtask

    // Send one character and record what the receiver should report for it.
    task automatic applyStimulus(input logic [7:0] dataByte, input logic parity,
                                 input logic stopBit);
        expFrame_t e;
        e.bus    = {1'b0, dataByte, parity, stopBit};
        e.parErr = (^dataByte) ^ parity;
        e.frmErr = ~stopBit;
        sbQ.push_back(e);
        driveBit(1'b0);
        for (int i = 0; i < 8; i++) begin
            driveBit(dataByte[i]);
        end
        driveBit(parity);
        driveBit(stopBit);
    endtask

    // Wait, with a bound, until every expected frame has been seen.
    task automatic waitDrain(input string tag);
        int n;
        n = 0;
        while (sbQ.size() != 0 && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput(tag, 32'(sbQ.size()), 32'd0);
    endtask

    // Scoreboard monitor: every strobe must match the oldest expected frame.
    always @(negedge clk) begin
        if (busy === 1'b1) begin
            busyCount++;
        end
        if (frameValid === 1'b1) begin
            validCount++;
            checkOutput("frameExpected", 32'(sbQ.size() > 0), 32'd1);
            if (sbQ.size() > 0) begin
                expFrame_t e;
                e = sbQ.pop_front();
                checkOutput("frameBus", 32'(informationBus), 32'(e.bus));
                checkOutput("frameParityError", 32'(parityError), 32'(e.parErr));
                checkOutput("frameFramingError", 32'(framingError), 32'(e.frmErr));
            end
        end
    end

    initial begin
        int savedValid;
        int savedBusy;
        logic [7:0] partial;

        checks     = 0;
        errors     = 0;
        validCount = 0;
        busyCount  = 0;
        rxSerial   = 1'b1;
        reset      = 1'b0;

        // Reset values.
        repeat (5) @(negedge clk);
        checkOutput("resetBus", 32'(informationBus), 32'h7FF);
        checkOutput("resetValid", 32'(frameValid), 32'd0);
        checkOutput("resetParityError", 32'(parityError), 32'd0);
        checkOutput("resetFramingError", 32'(framingError), 32'd0);
        checkOutput("resetBusy", 32'(busy), 32'd0);
        reset = 1'b1;
        repeat (20) @(negedge clk);

        // Case 1: clean 0xA5 frame; busy covers half a bit plus ten bits.
        $display("[TB] case 1: 0xA5 good frame");
        savedBusy = busyCount;
        applyStimulus(8'hA5, 1'b0, 1'b1);
        waitDrain("case1Drain");
        repeat (4) @(negedge clk);
        checkOutput("case1Bus", 32'(informationBus), 32'h295);
        checkOutput("case1BusyCycles", 32'(busyCount - savedBusy), 32'd168);
        checkOutput("case1BusyLow", 32'(busy), 32'd0);
        repeat (16) @(negedge clk);

        // Case 2: 0x01 with wrong parity.
        $display("[TB] case 2: 0x01 parity error");
        applyStimulus(8'h01, 1'b0, 1'b1);
        waitDrain("case2Drain");
        checkOutput("case2ParityError", 32'(parityError), 32'd1);
        repeat (16) @(negedge clk);

        // Case 3: 4-cycle glitch is rejected at mid-start-bit.
        $display("[TB] case 3: start glitch");
        savedValid = validCount;
        savedBusy  = busyCount;
        rxSerial = 1'b0;
        repeat (4) @(negedge clk);
        rxSerial = 1'b1;
        repeat (40) @(negedge clk);
        checkOutput("case3NoFrame", 32'(validCount - savedValid), 32'd0);
        checkOutput("case3BusyCycles", 32'(busyCount - savedBusy), 32'd8);
        checkOutput("case3BusyLow", 32'(busy), 32'd0);
        checkOutput("case3BusHeld", 32'(informationBus), 32'h005);
        checkOutput("case3ParityHeld", 32'(parityError), 32'd1);

        // Case 5: reset in the middle of data bit 4 discards the frame.
        $display("[TB] case 5: reset mid-frame");
        savedValid = validCount;
        partial = 8'h3C;
        driveBit(1'b0);
        for (int i = 0; i < 4; i++) begin
            driveBit(partial[i]);
        end
        rxSerial = partial[4];
        repeat (8) @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("case5ResetBus", 32'(informationBus), 32'h7FF);
        checkOutput("case5ResetValid", 32'(frameValid), 32'd0);
        checkOutput("case5ResetParityError", 32'(parityError), 32'd0);
        checkOutput("case5ResetFramingError", 32'(framingError), 32'd0);
        checkOutput("case5ResetBusy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        rxSerial = 1'b1;
        reset = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("case5NoPartialFrame", 32'(validCount - savedValid), 32'd0);
        applyStimulus(8'h3C, 1'b0, 1'b1);
        waitDrain("case5Drain");
        checkOutput("case5Bus", 32'(informationBus), 32'h0F1);
        repeat (16) @(negedge clk);

        // Case 4: break after a bad stop bit must not start a new frame.
        $display("[TB] case 4: framing error and break");
        applyStimulus(8'hFF, 1'b0, 1'b0);
        rxSerial = 1'b0;
        repeat (40) @(negedge clk);
        waitDrain("case4FirstDrain");
        checkOutput("case4FirstFramingError", 32'(framingError), 32'd1);
        savedValid = validCount;
        rxSerial = 1'b1;
        repeat (16) @(negedge clk);
        checkOutput("case4NoFrameInBreak", 32'(validCount - savedValid), 32'd0);
        applyStimulus(8'h3C, 1'b0, 1'b1);
        waitDrain("case4SecondDrain");
        checkOutput("case4SecondFramingError", 32'(framingError), 32'd0);
        repeat (16) @(negedge clk);

        // Case 6: back-to-back frames with no idle gap.
        $display("[TB] case 6: back-to-back frames");
        savedValid = validCount;
        applyStimulus(8'h55, 1'b0, 1'b1);
        applyStimulus(8'hAA, 1'b0, 1'b1);
        waitDrain("case6Drain");
        checkOutput("case6FrameCount", 32'(validCount - savedValid), 32'd2);
        checkOutput("case6Bus", 32'(informationBus), 32'h2A9);
        repeat (16) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
